// File: rtl/fir_sample_sequencer.sv
// Sample sequencer for a matched pair of FIR filters: issues one sample per
// period, captures both filter outputs after the latency and flags disagreement.
module fir_sample_sequencer #(
  parameter int WIDTH       = 16,
  parameter int PERIOD      = 128,
  parameter int LATENCY     = 4,
  parameter int NUM_SAMPLES = 800,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_sig,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] fir_sig_in,
  output logic                    fir_ready,
  input  logic signed [WIDTH-1:0] fir_sig,
  input  logic signed [WIDTH-1:0] fir_sig_sep,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_sig,
  output logic                    out_mismatch,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    busy,
  output logic                    done
);

  localparam int PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IN  = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_LAT = 3'd3;
  localparam logic [2:0] S_CAPTURE  = 3'd4;
  localparam logic [2:0] S_PAD      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]              r_state;
  logic [2:0]              w_state_nxt;
  logic [PER_W-1:0]        r_per_cnt;
  logic [PER_W-1:0]        w_per_nxt;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic signed [WIDTH-1:0] r_fir_sig_in;
  logic signed [WIDTH-1:0] r_out_sig;
  logic                    r_out_valid;
  logic                    r_out_mismatch;
  logic [CNT_W-1:0]        r_sample_cnt;
  logic [CNT_W-1:0]        r_err_cnt;
  logic [CNT_W-1:0]        w_sample_nxt;
  logic                    r_done;

  logic w_busy;
  logic w_abort;
  logic w_start;
  logic w_accept;
  logic w_capture;
  logic w_mismatch;
  logic w_last;
  logic w_lat_done;
  logic w_pad_done;

  assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_abort      = abort && w_busy;
  assign w_start      = start && !w_busy;
  assign w_accept     = (r_state == S_WAIT_IN) && in_valid && !abort;
  assign w_capture    = (r_state == S_CAPTURE) && !abort;
  assign w_mismatch   = (fir_sig != fir_sig_sep);
  assign w_sample_nxt = r_sample_cnt + 1'b1;
  assign w_last       = (w_sample_nxt == CNT_W'(NUM_SAMPLES));
  assign w_lat_done   = (r_lat_cnt == LAT_W'(LATENCY - 1));
  assign w_per_nxt    = r_per_cnt + 1'b1;
  // Compare the incremented count so the WAIT_IN handshake lands one cycle
  // before the next ISSUE, keeping fir_ready pulses exactly PERIOD apart.
  assign w_pad_done   = (w_per_nxt >= PER_W'(PERIOD - 2));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_state_nxt = S_WAIT_IN;
        S_WAIT_IN:      if (in_valid) w_state_nxt = S_ISSUE;
        S_ISSUE:        w_state_nxt = S_WAIT_LAT;
        S_WAIT_LAT:     if (w_lat_done) w_state_nxt = S_CAPTURE;
        S_CAPTURE:      w_state_nxt = w_last ? S_DONE : S_PAD;
        S_PAD:          if (w_pad_done) w_state_nxt = S_WAIT_IN;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_lat_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_per_cnt <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (r_state == S_WAIT_LAT || r_state == S_CAPTURE || r_state == S_PAD) begin
        r_per_cnt <= w_per_nxt;
      end
      if (r_state == S_WAIT_LAT) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fir_sig_in <= '0;
    end else if (w_accept) begin
      r_fir_sig_in <= in_sig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_sig      <= '0;
      r_out_mismatch <= 1'b0;
    end else begin
      r_out_valid <= w_capture;
      if (w_capture) begin
        r_out_sig      <= fir_sig;
        r_out_mismatch <= w_mismatch;
      end
    end
  end

  // Counters survive an abort so a cancelled run can still be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_done       <= 1'b0;
    end else if (w_start) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_done       <= 1'b0;
    end else if (w_capture) begin
      r_sample_cnt <= w_sample_nxt;
      if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_last) begin
        r_done <= 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == S_WAIT_IN);
  assign fir_ready    = (r_state == S_ISSUE);
  assign busy         = w_busy;
  assign fir_sig_in   = r_fir_sig_in;
  assign out_valid    = r_out_valid;
  assign out_sig      = r_out_sig;
  assign out_mismatch = r_out_mismatch;
  assign sample_cnt   = r_sample_cnt;
  assign err_cnt      = r_err_cnt;
  assign done         = r_done;

endmodule
